y86_dmem_unit: RTL
==================

# y86_dmem_unit

Parametrised data-memory stage for the Y86-64 processor, replacing the flag-triggered memory block with a clocked, handshaked unit. It sits between execute and write-back. It takes icode, valE, valA and valP from execute, performs the one memory access the instruction needs, and returns valM plus an address-error status. Stack and data share one unified, byte-addressed, word-organised array. Access latency is configurable.

## Interface
- DATA_W, 64, data word width in bits (multiple of 8)
- ADDR_W, 64, width of valE/valA/valP address operands
- DEPTH, 1024, number of DATA_W words in the array (power of two)
- WAIT_CYCLES, 1, array access latency in cycles (≥1)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute presents an instruction
- req_ready  out  1  unit can accept a request
- icode  in  4  Y86 instruction code
- val_e  in  ADDR_W  ALU result (address for rmmovq/mrmovq/pushq/call)
- val_a  in  DATA_W  store data; address for popq/ret
- val_p  in  DATA_W  return address stored by call
- resp_valid  out  1  result available
- resp_ready  in  1  write-back accepts result
- val_m  out  DATA_W  read data (0 for non-read instructions)
- dmem_error  out  1  address error for this response
- err_sticky  out  1  set on any error, cleared only by reset

## Operation
- Access map: 4 rmmovq writes val_a to [val_e]; 5 mrmovq reads [val_e]; 10 pushq writes val_a to [val_e]; 11 popq reads [val_a]; 8 call writes val_p to [val_e]; 9 ret reads [val_a]. All other icodes perform no access and respond with val_m=0, dmem_error=0.
- Byte address A maps to word index A >> log2(DATA_W/8).
- Error: word index ≥ DEPTH (all upper address bits included, no truncation). On error, no write is committed, val_m=0, dmem_error=1 and err_sticky is set.
- While err_sticky=1, writes are suppressed: the processor is in ADR state. Reads still complete.
- FSM states:
  - IDLE: req_ready=1. req_valid latches icode/val_e/val_a/val_p and moves to BUSY; the counter loads WAIT_CYCLES-1.
  - BUSY: the counter decrements. At 0, the write is committed or the read sampled into val_m, and the state moves to RESP.
  - RESP: resp_valid=1 with outputs held stable. resp_ready moves the state to IDLE.
- Array contents are unaffected by reset and undefined until written.

## Timing
- Reset values: req_ready=1, resp_valid=0, val_m=0, dmem_error=0, err_sticky=0. FSM resets to IDLE.
- Latency: request accepted at edge N gives resp_valid=1 after edge N+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+2 cycles. No overlap; req_ready=0 in BUSY and RESP.
- req_valid is ignored outside IDLE.
- resp_ready=1 on the first RESP cycle returns to IDLE on that edge. A new request can be accepted on the next edge.
- Reset asserted in BUSY: the access is dropped and no write is committed. Reset asserted in RESP: the response is lost.
- Read after write to the same address on back-to-back requests returns the new data.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: an address whose low log2(DATA_W/8) bits are nonzero is an error (same handling as out-of-range).
- DMEM_ALIGN_CHECK_EN undefined: those low bits are silently ignored.

## Structure
- Shared package y86_pkg holds:
  - icode constants (I_RMMOVQ=4, I_MRMOVQ=5, I_CALL=8, I_RET=9, I_PUSHQ=10, I_POPQ=11)
  - the FSM state enum
  - helper function for the address-to-word-index shift
- Sub-module y86_dmem_array: single-port synchronous RAM (DEPTH×DATA_W, write enable, registered read). The controller FSM, error logic and counter live in y86_dmem_unit.

## Test plan
- Defaults. rmmovq val_e=16 val_a=0xAB, then mrmovq val_e=16 → val_m=0xAB, dmem_error=0, resp_valid exactly 1 cycle after acceptance.
- pushq val_e=8184 val_a=0x55, then popq val_a=8184 → val_m=0x55. call val_e=8176 val_p=0x40, then ret val_a=8176 → val_m=0x40.
- mrmovq val_e=8192 → dmem_error=1, err_sticky=1, val_m=0. A following rmmovq val_e=0 val_a=7 does not write; mrmovq val_e=0 returns the prior value.
- resp_ready held 0 for 5 cycles in RESP → val_m/dmem_error stable, req_ready=0, new req_valid ignored.
- WAIT_CYCLES=3: rst_n pulsed low mid-BUSY of rmmovq val_e=24 → all outputs at reset values. A read of 24 after reset does not return the dropped data.
- DMEM_ALIGN_CHECK_EN defined: mrmovq val_e=12 → dmem_error=1. Undefined: it reads word 1 with dmem_error=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 data-memory stage: icodes, FSM states,
// and the byte-address to word-index shift helper.
package y86_pkg;

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } dmem_state_e;

  // Right-shift that turns a byte address into a word index.
  function automatic int unsigned word_shift(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Single-port synchronous RAM with registered read; contents have no reset.
module y86_dmem_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/y86_dmem_unit.sv
// Clocked, handshaked Y86-64 data-memory stage over a unified word array.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned addresses as errors.
module y86_dmem_unit
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] val_e,
  input  logic [DATA_W-1:0] val_a,
  input  logic [DATA_W-1:0] val_p,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] val_m,
  output logic              dmem_error,
  output logic              err_sticky
);

  localparam int unsigned SHIFT = word_shift(DATA_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AW    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [AW-1:0] LOW_MASK = (AW'(1) << SHIFT) - AW'(1);

  dmem_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        icode_q;
  logic [ADDR_W-1:0] val_e_q;
  logic [DATA_W-1:0] val_a_q, val_p_q;
  logic              rd_q, dmem_error_q, err_sticky_q;

  logic              is_read, is_write, addr_err, range_err, align_err, commit;
  logic [AW-1:0]     addr, upper;
  logic [DATA_W-1:0] wdata, rdata;
  logic              ram_en, ram_we;
  logic [IDX_W-1:0]  ram_addr;

  always_comb begin
    is_write = (icode_q == I_RMMOVQ) || (icode_q == I_PUSHQ) || (icode_q == I_CALL);
    is_read  = (icode_q == I_MRMOVQ) || (icode_q == I_POPQ) || (icode_q == I_RET);
    addr     = ((icode_q == I_POPQ) || (icode_q == I_RET)) ? AW'(val_a_q) : AW'(val_e_q);
    wdata    = (icode_q == I_CALL) ? val_p_q : val_a_q;
    // Any bit above the word index means out of range; nothing is truncated.
    upper     = addr >> (SHIFT + IDX_W);
    range_err = |upper;
`ifdef DMEM_ALIGN_CHECK_EN
    align_err = |(addr & LOW_MASK);
`else
    align_err = 1'b0;
`endif
    addr_err = (is_read || is_write) && (range_err || align_err);
    commit   = (state_q == StBusy) && (cnt_q == '0);
    ram_we   = commit && is_write && !addr_err && !err_sticky_q;
    ram_en   = ram_we || (commit && is_read && !addr_err);
    ram_addr = IDX_W'(addr >> SHIFT);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StBusy;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      icode_q      <= '0;
      val_e_q      <= '0;
      val_a_q      <= '0;
      val_p_q      <= '0;
      rd_q         <= 1'b0;
      dmem_error_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req_valid) begin
        icode_q <= icode;
        val_e_q <= val_e;
        val_a_q <= val_a;
        val_p_q <= val_p;
      end
      if (commit) begin
        rd_q         <= is_read && !addr_err;
        dmem_error_q <= addr_err;
        if (addr_err) begin
          err_sticky_q <= 1'b1;
        end
      end
    end
  end

  y86_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign val_m      = rd_q ? rdata : '0;
  assign dmem_error = dmem_error_q;
  assign err_sticky = err_sticky_q;

endmodule
